// File: rtl/hazard_unit.sv
// Pipeline hazard controller: load-use stall, taken-branch flush, memory-busy freeze.
// Outputs are combinational from state and current inputs; memBusy freezes the whole pipe.
module hazard_unit #(
    parameter int FLUSH_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  idRegSrcAddress,
    input  logic [3:0]  idRegDestAddress,
    input  logic        idUsesSrc,
    input  logic        idUsesDest,
    input  logic        exMemRead,
    input  logic [3:0]  exRegDestAddress,
    input  logic        branchTaken,
    input  logic        memBusy,
    output logic        pcWrite,
    output logic        ifIdWrite,
    output logic        makeMeBubble,
    output logic        ifIdFlush,
    output logic        pipeFreeze,
    output logic [15:0] stallCycles
);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        FLUSH   = 2'd1,
        MEMWAIT = 2'd2
    } state_t;

    localparam logic [3:0] BUBBLE_ADDR  = 4'b1111;
    localparam logic [1:0] FLUSH_RELOAD = 2'(FLUSH_CYCLES - 1);
    localparam state_t     BRANCH_NEXT  = (FLUSH_CYCLES > 1) ? FLUSH : RUN;

    state_t      state, state_nxt;
    logic [1:0]  flush_cnt, flush_cnt_nxt;
    logic        load_use;
    logic        in_flush;
    logic        stall_inc;

    assign load_use = exMemRead && (exRegDestAddress != BUBBLE_ADDR) &&
                      ((idUsesSrc  && (idRegSrcAddress  == exRegDestAddress)) ||
                       (idUsesDest && (idRegDestAddress == exRegDestAddress)));

    // Leaving MEMWAIT behaves exactly like the state it interrupted.
    assign in_flush = (state == FLUSH) || ((state == MEMWAIT) && (flush_cnt != 2'd0));

    always_comb begin
        pcWrite       = 1'b1;
        ifIdWrite     = 1'b1;
        makeMeBubble  = 1'b0;
        ifIdFlush     = 1'b0;
        pipeFreeze    = 1'b0;
        state_nxt     = state;
        flush_cnt_nxt = flush_cnt;

        if (memBusy) begin
            pcWrite    = 1'b0;
            ifIdWrite  = 1'b0;
            pipeFreeze = 1'b1;
            state_nxt  = MEMWAIT;
        end else if (branchTaken) begin
            ifIdFlush     = 1'b1;
            makeMeBubble  = 1'b1;
            flush_cnt_nxt = FLUSH_RELOAD;
            state_nxt     = BRANCH_NEXT;
        end else if (in_flush) begin
            ifIdFlush     = 1'b1;
            makeMeBubble  = 1'b1;
            flush_cnt_nxt = flush_cnt - 2'd1;
            state_nxt     = (flush_cnt == 2'd1) ? RUN : FLUSH;
        end else begin
            state_nxt = RUN;
            if (load_use) begin
                pcWrite      = 1'b0;
                ifIdWrite    = 1'b0;
                makeMeBubble = 1'b1;
            end
        end

        // Reset overrides the control outputs immediately, without waiting for a clock.
        if (!reset) begin
            pcWrite      = 1'b1;
            ifIdWrite    = 1'b1;
            makeMeBubble = 1'b0;
            ifIdFlush    = 1'b0;
            pipeFreeze   = 1'b0;
        end
    end

    assign stall_inc = !pcWrite || ifIdFlush;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= RUN;
            flush_cnt   <= 2'd0;
            stallCycles <= 16'd0;
        end else begin
            state     <= state_nxt;
            flush_cnt <= flush_cnt_nxt;
            if (stall_inc && (stallCycles != 16'hFFFF))
                stallCycles <= stallCycles + 16'd1;
        end
    end

endmodule

// File: tb/tb_hazard_unit.sv
// Directed bench for hazard_unit: one instance with FLUSH_CYCLES=3 and one at the default,
// both driven by the same stimulus.
module tb_hazard_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  idRegSrcAddress, idRegDestAddress, exRegDestAddress;
    logic        idUsesSrc, idUsesDest, exMemRead, branchTaken, memBusy;

    logic        pcWrite3, ifIdWrite3, makeMeBubble3, ifIdFlush3, pipeFreeze3;
    logic        pcWrite1, ifIdWrite1, makeMeBubble1, ifIdFlush1, pipeFreeze1;
    logic [15:0] stallCycles3, stallCycles1;

    int total = 0;
    int bad   = 0;

    // Packed as {pcWrite, ifIdWrite, makeMeBubble, ifIdFlush, pipeFreeze}
    localparam logic [4:0] NORM = 5'b11000;
    localparam logic [4:0] LU   = 5'b00100;
    localparam logic [4:0] FLSH = 5'b11110;
    localparam logic [4:0] FRZ  = 5'b00001;

    wire [4:0] o3 = {pcWrite3, ifIdWrite3, makeMeBubble3, ifIdFlush3, pipeFreeze3};
    wire [4:0] o1 = {pcWrite1, ifIdWrite1, makeMeBubble1, ifIdFlush1, pipeFreeze1};

    always #5 clk = ~clk;

    hazard_unit #(.FLUSH_CYCLES(3)) dut3 (
        .clk(clk), .reset(reset),
        .idRegSrcAddress(idRegSrcAddress), .idRegDestAddress(idRegDestAddress),
        .idUsesSrc(idUsesSrc), .idUsesDest(idUsesDest),
        .exMemRead(exMemRead), .exRegDestAddress(exRegDestAddress),
        .branchTaken(branchTaken), .memBusy(memBusy),
        .pcWrite(pcWrite3), .ifIdWrite(ifIdWrite3), .makeMeBubble(makeMeBubble3),
        .ifIdFlush(ifIdFlush3), .pipeFreeze(pipeFreeze3), .stallCycles(stallCycles3)
    );

    hazard_unit dut1 (
        .clk(clk), .reset(reset),
        .idRegSrcAddress(idRegSrcAddress), .idRegDestAddress(idRegDestAddress),
        .idUsesSrc(idUsesSrc), .idUsesDest(idUsesDest),
        .exMemRead(exMemRead), .exRegDestAddress(exRegDestAddress),
        .branchTaken(branchTaken), .memBusy(memBusy),
        .pcWrite(pcWrite1), .ifIdWrite(ifIdWrite1), .makeMeBubble(makeMeBubble1),
        .ifIdFlush(ifIdFlush1), .pipeFreeze(pipeFreeze1), .stallCycles(stallCycles1)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic edge_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        idRegSrcAddress  = 4'd0;
        idRegDestAddress = 4'd0;
        idUsesSrc        = 1'b0;
        idUsesDest       = 1'b0;
        exMemRead        = 1'b0;
        exRegDestAddress = 4'hF;
        branchTaken      = 1'b0;
        memBusy          = 1'b0;
    endtask

    task automatic set_load_use();
        exMemRead        = 1'b1;
        exRegDestAddress = 4'd3;
        idUsesSrc        = 1'b1;
        idRegSrcAddress  = 4'd3;
    endtask

    // Called just after a rising edge; finishes mid-cycle with reset released.
    task automatic do_reset();
        idle();
        reset = 1'b0;
        #2;
        reset = 1'b1;
        #1;
    endtask

    initial begin
        idle();
        reset   = 1'b0;
        memBusy = 1'b1;
        #2;
        chk("reset_out3", o3, NORM);
        chk("reset_out1", o1, NORM);
        chk("reset_stall3", stallCycles3, 16'd0);
        chk("reset_stall1", stallCycles1, 16'd0);
        edge_step();
        chk("reset_held_out3", o3, NORM);
        do_reset();

        // Load-use through the source field, then a bubble in EX clears it
        set_load_use();
        #1;
        chk("lu_src3", o3, LU);
        chk("lu_src1", o1, LU);
        edge_step();
        exRegDestAddress = 4'hF;
        #1;
        chk("lu_cleared3", o3, NORM);
        edge_step();
        chk("lu_stall3", stallCycles3, 16'd1);
        chk("lu_stall1", stallCycles1, 16'd1);

        // Bubble address never matches; dest field and enables
        exMemRead = 1'b1; exRegDestAddress = 4'hF; idUsesSrc = 1'b1; idRegSrcAddress = 4'hF;
        #1;
        chk("lu_bubble_addr", o3, NORM);
        idUsesSrc = 1'b0; idRegSrcAddress = 4'd5; idUsesDest = 1'b1;
        idRegDestAddress = 4'd5; exRegDestAddress = 4'd5;
        #1;
        chk("lu_dest", o3, LU);
        idUsesDest = 1'b0;
        #1;
        chk("lu_dest_unused", o3, NORM);
        idUsesDest = 1'b1; exMemRead = 1'b0;
        #1;
        chk("lu_no_memread", o3, NORM);
        idle();
        edge_step();
        chk("lu_stall_hold", stallCycles3, 16'd1);

        // Branch flush: three cycles at FLUSH_CYCLES=3, one at default; loadUse ignored in flush
        do_reset();
        branchTaken = 1'b1;
        #1;
        chk("br_c0_3", o3, FLSH);
        chk("br_c0_1", o1, FLSH);
        edge_step();
        branchTaken = 1'b0;
        #1;
        chk("br_c1_3", o3, FLSH);
        chk("br_c1_1", o1, NORM);
        set_load_use();
        #1;
        chk("br_lu_ignored3", o3, FLSH);
        chk("br_lu_run1", o1, LU);
        edge_step();
        idle();
        #1;
        chk("br_c2_3", o3, FLSH);
        edge_step();
        chk("br_done3", o3, NORM);
        chk("br_stall3", stallCycles3, 16'd3);
        chk("br_stall1", stallCycles1, 16'd2);

        // memBusy pauses an in-progress flush
        do_reset();
        branchTaken = 1'b1;
        edge_step();
        branchTaken = 1'b0;
        memBusy     = 1'b1;
        #1;
        chk("mb_frz0_3", o3, FRZ);
        edge_step();
        chk("mb_frz1_3", o3, FRZ);
        edge_step();
        memBusy = 1'b0;
        #1;
        chk("mb_resume3", o3, FLSH);
        chk("mb_resume1", o1, NORM);
        edge_step();
        chk("mb_last3", o3, FLSH);
        edge_step();
        chk("mb_done3", o3, NORM);
        chk("mb_stall3", stallCycles3, 16'd5);
        chk("mb_stall1", stallCycles1, 16'd3);

        // memBusy beats branch and loadUse; branch still high after release flushes
        do_reset();
        memBusy = 1'b1; branchTaken = 1'b1; set_load_use();
        #1;
        chk("pri_frz3", o3, FRZ);
        chk("pri_frz1", o1, FRZ);
        edge_step();
        memBusy = 1'b0;
        #1;
        chk("pri_br3", o3, FLSH);
        chk("pri_br1", o1, FLSH);
        edge_step();
        branchTaken = 1'b0;
        #1;
        chk("pri_after3", o3, FLSH);
        chk("pri_after1", o1, LU);
        edge_step();
        idle();
        chk("pri_stall3", stallCycles3, 16'd3);
        chk("pri_stall1", stallCycles1, 16'd3);

        // Branch dropped while frozen is not remembered
        do_reset();
        memBusy = 1'b1; branchTaken = 1'b1; set_load_use();
        edge_step();
        memBusy = 1'b0; branchTaken = 1'b0;
        #1;
        chk("pri_nobr3", o3, LU);
        idle();
        edge_step();

        // Reset mid-flush abandons it
        do_reset();
        branchTaken = 1'b1;
        edge_step();
        branchTaken = 1'b0;
        #1;
        chk("rst_fl_pre3", o3, FLSH);
        reset = 1'b0;
        #1;
        chk("rst_fl_out3", o3, NORM);
        chk("rst_fl_stall3", stallCycles3, 16'd0);
        reset = 1'b1;
        #1;
        chk("rst_fl_run3", o3, NORM);
        edge_step();
        chk("rst_fl_edge3", o3, NORM);
        chk("rst_fl_edge_stall3", stallCycles3, 16'd0);

        // Counter saturates, then async reset during the freeze
        memBusy = 1'b1;
        repeat (65540) @(posedge clk);
        #1;
        chk("sat_stall3", stallCycles3, 16'hFFFF);
        chk("sat_stall1", stallCycles1, 16'hFFFF);
        edge_step();
        chk("sat_hold3", stallCycles3, 16'hFFFF);
        chk("sat_frz3", o3, FRZ);
        reset = 1'b0;
        #1;
        chk("sat_rst_out3", o3, NORM);
        chk("sat_rst_out1", o1, NORM);
        chk("sat_rst_stall3", stallCycles3, 16'd0);
        chk("sat_rst_stall1", stallCycles1, 16'd0);
        reset = 1'b1;
        idle();
        edge_step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hazard_unit.md
HAZARD_UNIT -- requirements
Module: hazard_unit

Interface
REQ-001 SHALL have parameter FLUSH_CYCLES, default 1, legal range 1..3: number of cycles ID/EX receives a bubble after a taken branch.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on posedge clk.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port idRegSrcAddress  input  4  source register address of the instruction in ID.
REQ-005 SHALL have port idRegDestAddress  input  4  destination-field register address of the instruction in ID.
REQ-006 SHALL have port idUsesSrc  input  1  the ID instruction reads idRegSrcAddress.
REQ-007 SHALL have port idUsesDest  input  1  the ID instruction reads idRegDestAddress.
REQ-008 SHALL have port exMemRead  input  1  oMemRead of the ID/EX buffer.
REQ-009 SHALL have port exRegDestAddress  input  4  oRegDestAddress of the ID/EX buffer; 4'b1111 marks a bubble.
REQ-010 SHALL have port branchTaken  input  1  a taken branch resolved in EX this cycle.
REQ-011 SHALL have port memBusy  input  1  data memory needs more cycles; whole pipe must hold.
REQ-012 SHALL have port pcWrite  output  1  1 = PC may update.
REQ-013 SHALL have port ifIdWrite  output  1  1 = IF/ID buffer may load.
REQ-014 SHALL have port makeMeBubble  output  1  drives the ID/EX buffer bubble input.
REQ-015 SHALL have port ifIdFlush  output  1  clear the IF/ID buffer at the next edge.
REQ-016 SHALL have port pipeFreeze  output  1  hold ID/EX, EX/MEM and MEM/WB buffers.
REQ-017 SHALL have port stallCycles  output  16  saturating count of lost cycles.

Function
REQ-018 SHALL implement states RUN, FLUSH, MEMWAIT in a registered state machine; outputs combinational from state and current inputs.
REQ-019 SHALL define loadUse = exMemRead and exRegDestAddress != 4'b1111 and ((idUsesSrc and idRegSrcAddress == exRegDestAddress) or (idUsesDest and idRegDestAddress == exRegDestAddress)).
REQ-020 SHALL apply priority memBusy > branchTaken > FLUSH state > loadUse > normal.
REQ-021 memBusy=1 (any state): pcWrite=0, ifIdWrite=0, pipeFreeze=1, makeMeBubble=0, ifIdFlush=0; next state MEMWAIT; FLUSH remaining-count held unchanged.
REQ-022 MEMWAIT with memBusy=0: return to FLUSH if flush count remaining is nonzero, else RUN; outputs this cycle evaluated as in that target state.
REQ-023 branchTaken=1, memBusy=0: ifIdFlush=1, makeMeBubble=1, pcWrite=1, ifIdWrite=1; flush count loaded with FLUSH_CYCLES-1; next state FLUSH if FLUSH_CYCLES>1, else RUN.
REQ-024 FLUSH, no memBusy/branchTaken: ifIdFlush=1, makeMeBubble=1, pcWrite=1; count decrements; RUN when count reaches 0 after decrement.
REQ-025 RUN, loadUse=1: pcWrite=0, ifIdWrite=0, makeMeBubble=1 for exactly that cycle; no state change (next cycle ID/EX holds 4'b1111, clearing loadUse).
REQ-026 RUN, no hazard: pcWrite=1, ifIdWrite=1, makeMeBubble=0, ifIdFlush=0, pipeFreeze=0.
REQ-027 branchTaken in FLUSH SHALL reload the count (new branch wins).
REQ-028 loadUse SHALL be ignored while branchTaken or FLUSH applies (the ID instruction is flushed).
REQ-029 stallCycles SHALL increment by 1 on each edge where pcWrite=0 or ifIdFlush=1, saturating at 16'hFFFF (no wrap).

Reset
REQ-030 reset=0 SHALL immediately force state RUN, flush count 0, stallCycles 0, pcWrite=1, ifIdWrite=1, makeMeBubble=0, ifIdFlush=0, pipeFreeze=0, independent of clk.
REQ-031 Reset asserted mid-FLUSH or mid-MEMWAIT SHALL abandon the operation; first edge after release evaluates from RUN.

Verification
REQ-032 exMemRead=1, exRegDestAddress=3, idUsesSrc=1, idRegSrcAddress=3 for one cycle -> pcWrite=0, ifIdWrite=0, makeMeBubble=1 that cycle only; stallCycles +1.
REQ-033 Same as REQ-032 but exRegDestAddress=4'b1111 and idRegSrcAddress=4'b1111 -> no stall, makeMeBubble=0.
REQ-034 FLUSH_CYCLES=3, branchTaken pulse -> ifIdFlush=1, makeMeBubble=1 for 3 consecutive cycles, then RUN; stallCycles +3.
REQ-035 FLUSH_CYCLES=3, memBusy=1 for 2 cycles starting the cycle after branch -> flush pauses (pipeFreeze=1, ifIdFlush=0), then 2 more flush cycles.
REQ-036 memBusy=1 with simultaneous loadUse and branchTaken -> only freeze outputs; after release, branch flush applied in that same cycle only if branchTaken still 1.
REQ-037 Preload stallCycles to 16'hFFFF via continuous stall -> stays 16'hFFFF; reset=0 mid-stall -> all outputs at reset values asynchronously.
